// File: rtl/rx_frm_ctrl_pkg.sv
// rx_frm_ctrl_pkg: STM-1 framing constants and framer state encoding shared by the frame controller
package rx_frm_ctrl_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, PRESYNC = 2'd1, SYNC = 2'd2} st_t;
  localparam int STM1_FRM_LEN = 2430;
  localparam int COLS = 270;
  localparam int ROWS = 9;
  localparam int TOH_COLS = 9;
endpackage

// File: rtl/rx_frm_ctrl_lof_tmr.sv
// lof_tmr: persistence filter turning the out-of-frame flag into the loss-of-frame flag
// ports: clk/rst (sync, active-high), oof in, lof out (changes only after oof differs for LOF_CLK cycles)
module lof_tmr import rx_frm_ctrl_pkg::*; #(
  parameter int LOF_CLK = 58320
) (
  input  logic clk,
  input  logic rst,
  input  logic oof,
  output logic lof
);
  localparam int W = $clog2(LOF_CLK);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      lof <= 1'b0;
    end else if (oof == lof) cnt <= '0;
    else if (cnt == W'(LOF_CLK - 1)) begin
      cnt <= '0;
      lof <= ~lof;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/rx_frm_ctrl.sv
// rx_frm_ctrl: STM-1 receive frame controller (hunt/presync/sync FSM, byte/row/col counter, OOF/LOF)
// ports: clk19/rst19 byte clock and sync reset; sof start-of-frame pulse; frc_hunt CPU re-hunt request;
//        state, oof, lof, rehunt, fvld, bcnt, row, col, toh all registered outputs
module rx_frm_ctrl import rx_frm_ctrl_pkg::*; #(
  parameter int FRM_LEN = STM1_FRM_LEN,
  parameter int PRE_N   = 2,
  parameter int OOF_N   = 4,
  parameter int LOF_CLK = 58320
) (
  input  logic        clk19,
  input  logic        rst19,
  input  logic        sof,
  input  logic        frc_hunt,
  output logic [1:0]  state,
  output logic        oof,
  output logic        lof,
  output logic        rehunt,
  output logic        fvld,
  output logic [11:0] bcnt,
  output logic [3:0]  row,
  output logic [8:0]  col,
  output logic        toh
);
  st_t st, st_nxt;
  logic [7:0] good, good_nxt, err, err_nxt;
  logic rh, load, at_exp, wrap, col_end;
  logic [11:0] bcnt_nxt;
  logic [3:0] row_nxt;
  logic [8:0] col_nxt;
  // the expected position is the last byte of the frame: a sof sampled here lands on byte 0
  assign at_exp = bcnt == 12'(FRM_LEN - 1);
  assign wrap = load | at_exp;
  assign col_end = col == 9'(COLS - 1);
  assign bcnt_nxt = wrap ? '0 : bcnt + 12'd1;
  assign col_nxt = (wrap | col_end) ? '0 : col + 9'd1;
  assign row_nxt = wrap ? '0 : col_end ? (row == 4'(ROWS - 1) ? '0 : row + 4'd1) : row;
  assign state = st;
  always_comb begin
    st_nxt = st;
    good_nxt = good;
    err_nxt = err;
    rh = 1'b0;
    load = 1'b0;
    if (frc_hunt) begin
      st_nxt = HUNT;
      good_nxt = '0;
      err_nxt = '0;
      rh = 1'b1;
    end else
      case (st)
        HUNT:
          if (sof) begin
            st_nxt = PRESYNC;
            good_nxt = 8'd1;
            load = 1'b1;
          end
        PRESYNC:
          if (sof != at_exp) begin
            st_nxt = HUNT;
            good_nxt = '0;
            rh = 1'b1;
          end else if (at_exp) begin
            good_nxt = good + 8'd1;
            st_nxt = good_nxt >= 8'(PRE_N) ? SYNC : PRESYNC;
          end
        SYNC:
          if (at_exp) begin
            err_nxt = sof ? '0 : err + 8'd1;
            if (err_nxt >= 8'(OOF_N)) begin
              st_nxt = HUNT;
              err_nxt = '0;
              good_nxt = '0;
              rh = 1'b1;
            end
          end
        default: st_nxt = HUNT;
      endcase
  end
  always_ff @(posedge clk19)
    if (rst19) begin
      st <= HUNT;
      good <= '0;
      err <= '0;
    end else begin
      st <= st_nxt;
      good <= good_nxt;
      err <= err_nxt;
    end
  // rehunt is masked by its own previous value so back-to-back requests never stretch the pulse
  always_ff @(posedge clk19)
    if (rst19) begin
      oof <= 1'b1;
      rehunt <= 1'b0;
      fvld <= 1'b0;
      toh <= 1'b0;
      bcnt <= '0;
      row <= '0;
      col <= '0;
    end else begin
      oof <= st_nxt != SYNC;
      rehunt <= rh & ~rehunt;
      fvld <= st_nxt != HUNT;
      toh <= (st_nxt != HUNT) && (col_nxt < 9'(TOH_COLS));
      bcnt <= bcnt_nxt;
      row <= row_nxt;
      col <= col_nxt;
    end
  lof_tmr #(.LOF_CLK(LOF_CLK)) u_lof (.clk(clk19), .rst(rst19), .oof(oof), .lof(lof));
endmodule

// File: tb/tb_rx_frm_ctrl.sv
// tb_rx_frm_ctrl: directed self-checking bench for rx_frm_ctrl with a shortened LOF persistence
module tb_rx_frm_ctrl;
  logic clk19 = 1'b0, rst19 = 1'b1, sof = 1'b0, frc_hunt = 1'b0;
  logic [1:0] state;
  logic oof, lof, rehunt, fvld, toh;
  logic [11:0] bcnt;
  logic [3:0] row;
  logic [8:0] col;
  int passed = 0, total = 0;
  always #5 clk19 = ~clk19;
  rx_frm_ctrl #(.LOF_CLK(100)) dut (
    .clk19(clk19), .rst19(rst19), .sof(sof), .frc_hunt(frc_hunt),
    .state(state), .oof(oof), .lof(lof), .rehunt(rehunt), .fvld(fvld),
    .bcnt(bcnt), .row(row), .col(col), .toh(toh)
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk19);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s got=%0d want=%0d", tag, got, want);
  endtask
  task automatic pulse(input logic s, input logic f);
    sof = s;
    frc_hunt = f;
    tick(1);
    sof = 1'b0;
    frc_hunt = 1'b0;
  endtask
  initial begin
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_oof", oof, 1);
    chk("rst_lof", lof, 0);
    chk("rst_rehunt", rehunt, 0);
    chk("rst_fvld", fvld, 0);
    chk("rst_toh", toh, 0);
    chk("rst_bcnt", bcnt, 0);
    rst19 = 1'b0;
    tick(99);
    chk("lof_99", lof, 0);
    tick(1);
    chk("lof_100", lof, 1);
    chk("hunt_bcnt", bcnt, 100);
    chk("hunt_fvld", fvld, 0);
    chk("hunt_toh", toh, 0);
    pulse(1, 0);
    chk("sof1_state", state, 1);
    chk("sof1_bcnt", bcnt, 0);
    chk("sof1_fvld", fvld, 1);
    chk("sof1_toh", toh, 1);
    chk("sof1_oof", oof, 1);
    tick(278);
    chk("b278_col", col, 8);
    chk("b278_toh", toh, 1);
    tick(1);
    chk("b279_row", row, 1);
    chk("b279_col", col, 9);
    chk("b279_toh", toh, 0);
    tick(2150);
    chk("pre_bcnt", bcnt, 2429);
    chk("pre_state", state, 1);
    pulse(1, 0);
    chk("sof2_state", state, 2);
    chk("sof2_oof", oof, 0);
    chk("sof2_bcnt", bcnt, 0);
    tick(99);
    chk("lofclr_99", lof, 1);
    tick(1);
    chk("lofclr_100", lof, 0);
    tick(2329);
    tick(2430);
    tick(2430);
    tick(2430);
    chk("drop3_state", state, 2);
    chk("drop3_oof", oof, 0);
    pulse(1, 0);
    chk("restore_state", state, 2);
    tick(2429);
    tick(2430);
    tick(2430);
    tick(2430);
    chk("redrop3_state", state, 2);
    tick(1);
    chk("drop4_state", state, 0);
    chk("drop4_rehunt", rehunt, 1);
    chk("drop4_oof", oof, 1);
    chk("drop4_fvld", fvld, 0);
    tick(1);
    chk("drop4_rehunt_end", rehunt, 0);
    pulse(1, 0);
    chk("p2_state", state, 1);
    tick(1229);
    pulse(1, 0);
    chk("early_state", state, 0);
    chk("early_rehunt", rehunt, 1);
    tick(1);
    chk("early_rehunt_end", rehunt, 0);
    pulse(1, 0);
    tick(2429);
    pulse(1, 0);
    chk("s2_state", state, 2);
    tick(2429);
    pulse(1, 1);
    chk("frc_state", state, 0);
    chk("frc_rehunt", rehunt, 1);
    chk("frc_oof", oof, 1);
    chk("frc_bcnt", bcnt, 0);
    tick(1);
    chk("frc_rehunt_end", rehunt, 0);
    tick(8);
    pulse(1, 1);
    chk("frc_hunt_state", state, 0);
    chk("frc_hunt_bcnt", bcnt, 10);
    chk("frc_hunt_rehunt", rehunt, 1);
    tick(1);
    chk("gap_rehunt", rehunt, 0);
    frc_hunt = 1'b1;
    tick(1);
    chk("hold1_rehunt", rehunt, 1);
    tick(1);
    chk("hold2_rehunt", rehunt, 0);
    frc_hunt = 1'b0;
    pulse(1, 0);
    tick(2429);
    pulse(1, 0);
    tick(1500);
    chk("mid_state", state, 2);
    chk("mid_bcnt", bcnt, 1500);
    rst19 = 1'b1;
    sof = 1'b1;
    frc_hunt = 1'b1;
    tick(1);
    chk("mrst_state", state, 0);
    chk("mrst_oof", oof, 1);
    chk("mrst_lof", lof, 0);
    chk("mrst_rehunt", rehunt, 0);
    chk("mrst_fvld", fvld, 0);
    chk("mrst_toh", toh, 0);
    chk("mrst_bcnt", bcnt, 0);
    chk("mrst_row", row, 0);
    chk("mrst_col", col, 0);
    rst19 = 1'b0;
    sof = 1'b0;
    frc_hunt = 1'b0;
    tick(1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
